uart_blk_rx: RTL and testbench

//  Parametrised UART block receiver, successor to the fixed-format CRC block receiver.

---
 rtl/uart_blk_pkg.sv | 47 ++++
 rtl/uart_blk_rx_byte.sv | 114 +++++++++++
 rtl/uart_blk_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_blk_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_blk_pkg.sv
// Shared types, error codes and helper functions for the UART block receiver.
package uart_blk_pkg;

  // Block-level FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_COM  = 3'd1,
    ST_ADR  = 3'd2,
    ST_LEN  = 3'd3,
    ST_DAT  = 3'd4,
    ST_CRC  = 3'd5
  } blk_state_t;

  // Byte receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Cause codes reported on err_code
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CRC     = 2'd3;

  // Clock cycles per bit, rounded to nearest
  function automatic int calc_bit_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // One byte of CRC-8, MSB first, bit-serial form
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [7:0] dat,
                                           input logic [7:0] poly);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ dat[i];
      c  = {c[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_blk_rx_byte.sv
// UART byte receiver: 2-FF synchroniser, start detection with false-start
// rejection, centre sampling of 8 data bits (LSB first) and the stop bit.
module uart_byte_rx
  import uart_blk_pkg::*;
#(
  parameter int BIT_DIV = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic       o_ce_bit,
  output logic       o_active,
  output logic       o_start,
  output logic       o_byte_ok,
  output logic       o_byte_ferr,
  output logic [7:0] o_byte_dat
);

  localparam int            CW      = $clog2(BIT_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_DIV - 1);

  logic [1:0]    r_sync;
  logic          r_prev;
  rx_state_t     r_st;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;

  logic w_line;
  logic w_fall;

  assign w_line     = r_sync[1];
  assign w_fall     = r_prev & ~w_line;
  // Start is visible combinationally so the block timeout can yield to it
  assign o_start    = (r_st == RX_IDLE) & w_fall;
  assign o_active   = (r_st != RX_IDLE);
  assign o_byte_dat = r_sh;

  // Synchronise rxd and remember the previous synced level (reset to idle-high)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
      r_prev <= w_line;
    end
  end

  // Bit timing: half-bit start check, then full-bit steps to each centre
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st        <= RX_IDLE;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_sh        <= 8'h00;
      o_ce_bit    <= 1'b0;
      o_byte_ok   <= 1'b0;
      o_byte_ferr <= 1'b0;
    end else begin
      o_ce_bit    <= 1'b0;
      o_byte_ok   <= 1'b0;
      o_byte_ferr <= 1'b0;
      case (r_st)
        RX_IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_st <= RX_START;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            r_bit <= 3'd0;
            // A line already back high at the start centre was a glitch
            r_st  <= w_line ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_M1) begin
            r_cnt    <= '0;
            o_ce_bit <= 1'b1;
            r_sh     <= {w_line, r_sh[7:1]};
            if (r_bit == 3'd7) begin
              r_st <= RX_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_M1) begin
            r_cnt       <= '0;
            o_ce_bit    <= 1'b1;
            r_st        <= RX_IDLE;
            o_byte_ok   <= w_line;
            o_byte_ferr <= ~w_line;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_st <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_blk_rx.sv
// UART block receiver: parses LBL/COM/ADR/LEN/data/CRC8 frames, emits one
// write strobe per data byte with an auto-incremented address and reports
// each block as a one-cycle ok or error pulse with a cause code.
module uart_blk_rx
  import uart_blk_pkg::*;
#(
  parameter int         CLK_HZ   = 50_000_000,
  parameter int         BAUD     = 115200,
  parameter int         ADR_W    = 16,
  parameter int         MAX_LEN  = 255,
  parameter logic [7:0] LBL      = 8'hA5,
  parameter logic [7:0] CRC_POLY = 8'h07,
  parameter int         GAP_BITS = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic             ce_bit,
  output logic             ce_wr_dat,
  output logic [7:0]       rx_dat,
  output logic [ADR_W-1:0] wr_adr,
  output logic [7:0]       com,
  output logic [7:0]       rx_lbl,
  output logic             busy,
  output logic             ok_rx_bl,
  output logic             err_rx_bl,
  output logic [1:0]       err_code
);

  localparam int BIT_DIV   = calc_bit_div(CLK_HZ, BAUD);
  // Gap measured from the stop-bit centre, so add the half bit to its end
  localparam int GAP_LIM   = GAP_BITS * BIT_DIV + BIT_DIV / 2;
  localparam int GW        = $clog2(GAP_LIM + 1);
  localparam int ADR_BYTES = ADR_W / 8;

  logic             w_active;
  logic             w_start;
  logic             w_byte_ok;
  logic             w_byte_ferr;
  logic [7:0]       w_byte_dat;
  logic             w_timeout;

  blk_state_t       r_state;
  logic [ADR_W-1:0] r_adr;
  logic [1:0]       r_bcnt;
  logic [7:0]       r_len;
  logic [7:0]       r_idx;
  logic [7:0]       r_crc;
  logic [GW-1:0]    r_gap;

  uart_byte_rx #(
    .BIT_DIV (BIT_DIV)
  ) u_byte_rx (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rxd       (rxd),
    .o_ce_bit    (ce_bit),
    .o_active    (w_active),
    .o_start     (w_start),
    .o_byte_ok   (w_byte_ok),
    .o_byte_ferr (w_byte_ferr),
    .o_byte_dat  (w_byte_dat)
  );

  // A start detected in the expiry cycle cancels the timeout
  assign w_timeout = (r_state != ST_IDLE) && !w_active && !w_start &&
                     !w_byte_ok && !w_byte_ferr &&
                     (r_gap == GW'(GAP_LIM - 1));

  // Inter-byte gap counter: runs only while a block is open and the line is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gap <= '0;
    end else if ((r_state == ST_IDLE) || w_active || w_start ||
                 w_byte_ok || w_byte_ferr) begin
      r_gap <= '0;
    end else begin
      r_gap <= r_gap + GW'(1);
    end
  end

  // Block FSM: field parsing, address counting, CRC and result reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_bcnt    <= 2'd0;
      r_len     <= 8'h00;
      r_idx     <= 8'h00;
      r_crc     <= 8'h00;
      ce_wr_dat <= 1'b0;
      rx_dat    <= 8'h00;
      wr_adr    <= '0;
      com       <= 8'h00;
      rx_lbl    <= 8'h00;
      busy      <= 1'b0;
      ok_rx_bl  <= 1'b0;
      err_rx_bl <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      ce_wr_dat <= 1'b0;
      ok_rx_bl  <= 1'b0;
      err_rx_bl <= 1'b0;
      if ((r_state != ST_IDLE) && w_byte_ferr) begin
        err_rx_bl <= 1'b1;
        err_code  <= ERR_FRAME;
        busy      <= 1'b0;
        r_state   <= ST_IDLE;
      end else if (w_timeout) begin
        err_rx_bl <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        busy      <= 1'b0;
        r_state   <= ST_IDLE;
      end else if (w_byte_ok) begin
        case (r_state)
          ST_IDLE: begin
            if (w_byte_dat == LBL) begin
              rx_lbl  <= w_byte_dat;
              busy    <= 1'b1;
              r_state <= ST_COM;
            end
          end
          ST_COM: begin
            com     <= w_byte_dat;
            r_crc   <= crc8_step(8'h00, w_byte_dat, CRC_POLY);
            r_bcnt  <= 2'd0;
            r_state <= ST_ADR;
          end
          ST_ADR: begin
            // Shifting in ADR_BYTES bytes fully replaces the previous address
            r_adr  <= (r_adr << 4'd8) | ADR_W'(w_byte_dat);
            r_crc  <= crc8_step(r_crc, w_byte_dat, CRC_POLY);
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'(ADR_BYTES - 1)) begin
              r_state <= ST_LEN;
            end
          end
          ST_LEN: begin
            r_crc <= crc8_step(r_crc, w_byte_dat, CRC_POLY);
            r_len <= w_byte_dat;
            r_idx <= 8'h00;
            if (w_byte_dat == 8'h00) begin
              r_state <= ST_CRC;
            end else if ({24'd0, w_byte_dat} > 32'(MAX_LEN)) begin
              err_rx_bl <= 1'b1;
              err_code  <= ERR_CRC;
              busy      <= 1'b0;
              r_state   <= ST_IDLE;
            end else begin
              r_state <= ST_DAT;
            end
          end
          ST_DAT: begin
            ce_wr_dat <= 1'b1;
            rx_dat    <= w_byte_dat;
            wr_adr    <= r_adr;
            r_adr     <= r_adr + ADR_W'(1);
            r_crc     <= crc8_step(r_crc, w_byte_dat, CRC_POLY);
            r_idx     <= r_idx + 8'd1;
            if (r_idx == (r_len - 8'd1)) begin
              r_state <= ST_CRC;
            end
          end
          ST_CRC: begin
            if (w_byte_dat == r_crc) begin
              ok_rx_bl <= 1'b1;
            end else begin
              err_rx_bl <= 1'b1;
              err_code  <= ERR_CRC;
            end
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_blk_rx.sv
// Directed testbench for uart_blk_rx at 10 clocks per bit.
module tb_uart_blk_rx;

  localparam int BIT = 10;

  logic        clk;
  logic        rst;
  logic        rxd;
  logic        ce_bit;
  logic        ce_wr_dat;
  logic [7:0]  rx_dat;
  logic [15:0] wr_adr;
  logic [7:0]  com;
  logic [7:0]  rx_lbl;
  logic        busy;
  logic        ok_rx_bl;
  logic        err_rx_bl;
  logic [1:0]  err_code;

  uart_blk_rx #(
    .CLK_HZ  (1_000_000),
    .BAUD    (100_000),
    .ADR_W   (16),
    .MAX_LEN (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .ce_bit    (ce_bit),
    .ce_wr_dat (ce_wr_dat),
    .rx_dat    (rx_dat),
    .wr_adr    (wr_adr),
    .com       (com),
    .rx_lbl    (rx_lbl),
    .busy      (busy),
    .ok_rx_bl  (ok_rx_bl),
    .err_rx_bl (err_rx_bl),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Event monitor, sampled on the inactive edge
  int          n_ok  = 0;
  int          n_err = 0;
  int          n_ce  = 0;
  logic [15:0] q_adr[$];
  logic [7:0]  q_dat[$];

  always @(negedge clk) begin
    if (ok_rx_bl)  n_ok++;
    if (err_rx_bl) n_err++;
    if (ce_bit)    n_ce++;
    if (ce_wr_dat) begin
      q_adr.push_back(wr_adr);
      q_dat.push_back(rx_dat);
    end
  end

  logic [7:0] fr[0:7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks the idx-th recorded write strobe; a missing strobe reads as all ones
  task automatic chk_wr(input string tag, input int idx, input logic [15:0] ea, input logic [7:0] ed);
    logic [31:0] got;
    got = (idx < q_adr.size()) ? {8'h00, q_adr[idx], q_dat[idx]} : 32'hFFFF_FFFF;
    chk(tag, got, {8'h00, ea, ed});
  endtask

  function automatic logic [7:0] ref_crc(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 1; k < n; k++) begin
      c = c ^ fr[k];
      for (int j = 0; j < 8; j++) begin
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic load(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) fr[k] = v[8*(n-1-k) +: 8];
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(posedge clk);
    end
    rxd = stop_v;
    repeat (BIT) @(posedge clk);
    rxd = 1'b1;
    if (!stop_v) repeat (BIT) @(posedge clk);
  endtask

  task automatic send_frame(input int n, input bit with_crc, input logic [7:0] crc_xor, input int bad_stop);
    for (int k = 0; k < n; k++) send_byte(fr[k], (k == bad_stop) ? 1'b0 : 1'b1);
    if (with_crc) send_byte(ref_crc(n) ^ crc_xor, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * BIT) @(posedge clk);
    @(negedge clk);
  endtask

  int b_wr, b_ok, b_err, b_ce, t;
  bit found;

  initial begin
    rxd = 1'b1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {26'd0, ce_bit, ce_wr_dat, busy, ok_rx_bl, err_rx_bl, 1'b0} | {30'd0, err_code}, 32'd0);
    chk("rst_regs", {8'h00, com, rx_lbl, rx_dat}, 32'd0);
    chk("rst_adr", {16'h0000, wr_adr}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    idle_bits(2);

    // 1: basic three-byte block
    b_wr = q_adr.size(); b_ok = n_ok; b_err = n_err; b_ce = n_ce;
    load(64'hA5_01_12_34_03_AA_BB_CC, 8);
    send_frame(8, 1'b1, 8'h00, -1);
    idle_bits(3);
    chk("t1_nwr", q_adr.size() - b_wr, 3);
    chk_wr("t1_wr0", b_wr,     16'h1234, 8'hAA);
    chk_wr("t1_wr1", b_wr + 1, 16'h1235, 8'hBB);
    chk_wr("t1_wr2", b_wr + 2, 16'h1236, 8'hCC);
    chk("t1_com", com, 8'h01);
    chk("t1_lbl", rx_lbl, 8'hA5);
    chk("t1_ok", n_ok - b_ok, 1);
    chk("t1_err", n_err - b_err, 0);
    chk("t1_cebit", n_ce - b_ce, 81);
    chk("t1_busy", busy, 0);

    // 2: corrupted CRC
    b_wr = q_adr.size(); b_ok = n_ok; b_err = n_err;
    send_frame(8, 1'b1, 8'h01, -1);
    idle_bits(3);
    chk("t2_nwr", q_adr.size() - b_wr, 3);
    chk("t2_err", n_err - b_err, 1);
    chk("t2_code", err_code, 2'd3);
    chk("t2_ok", n_ok - b_ok, 0);

    // 3: address wrap
    b_wr = q_adr.size(); b_ok = n_ok;
    load(64'hA5_02_FF_FF_02_11_22, 7);
    send_frame(7, 1'b1, 8'h00, -1);
    idle_bits(3);
    chk_wr("t3_wr0", b_wr,     16'hFFFF, 8'h11);
    chk_wr("t3_wr1", b_wr + 1, 16'h0000, 8'h22);
    chk("t3_ok", n_ok - b_ok, 1);
    chk("t3_com", com, 8'h02);

    // 4: line goes idle after the address
    load(64'hA5_01_00_10, 4);
    send_frame(4, 1'b0, 8'h00, -1);
    chk("t4_busy_hi", busy, 1);
    t = 0; found = 1'b0;
    while (t < 45 * BIT && !found) begin
      @(negedge clk);
      t++;
      if (err_rx_bl) found = 1'b1;
    end
    chk("t4_seen", found, 1);
    chk("t4_in_window", (t >= 395) && (t <= 415), 1);
    chk("t4_code", err_code, 2'd2);
    chk("t4_busy_lo", busy, 0);
    idle_bits(2);

    // 5: glitch, then framing error on COM
    b_ce = n_ce; b_err = n_err; b_ok = n_ok; b_wr = q_adr.size();
    @(posedge clk);
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    idle_bits(12);
    chk("t5_glitch_cebit", n_ce - b_ce, 0);
    load(64'hA5_01, 2);
    send_frame(2, 1'b0, 8'h00, 1);
    idle_bits(3);
    chk("t5_err", n_err - b_err, 1);
    chk("t5_code", err_code, 2'd1);
    chk("t5_ok", n_ok - b_ok, 0);
    chk("t5_busy", busy, 0);

    // 6: LEN above MAX_LEN
    b_err = n_err; b_ok = n_ok; b_wr = q_adr.size();
    load(64'hA5_03_00_20_FF, 5);
    send_frame(5, 1'b0, 8'h00, -1);
    idle_bits(3);
    chk("t6_err", n_err - b_err, 1);
    chk("t6_code", err_code, 2'd3);
    chk("t6_nwr", q_adr.size() - b_wr, 0);
    chk("t6_ok", n_ok - b_ok, 0);

    // 7: reset in the data phase
    b_err = n_err; b_ok = n_ok; b_wr = q_adr.size();
    load(64'hA5_01_00_40_04_11_22, 7);
    send_frame(7, 1'b0, 8'h00, -1);
    chk("t7_pre_nwr", q_adr.size() - b_wr, 2);
    chk("t7_pre_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_rst_regs", {8'h00, com, rx_lbl, rx_dat}, 32'd0);
    chk("t7_rst_adr", {16'h0000, wr_adr}, 32'd0);
    chk("t7_rst_ctrl", {29'd0, busy, err_code}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    idle_bits(50);
    chk("t7_no_err", n_err - b_err, 0);
    b_wr = q_adr.size();
    load(64'hA5_05_00_00_01_77, 6);
    send_frame(6, 1'b1, 8'h00, -1);
    idle_bits(3);
    chk_wr("t7_wr0", b_wr, 16'h0000, 8'h77);
    chk("t7_ok", n_ok - b_ok, 1);

    // 8: garbage before the label
    b_ok = n_ok; b_err = n_err; b_wr = q_adr.size();
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    load(64'hA5_06_AB_CD_01_99, 6);
    send_frame(6, 1'b1, 8'h00, -1);
    idle_bits(3);
    chk("t8_ok", n_ok - b_ok, 1);
    chk("t8_err", n_err - b_err, 0);
    chk_wr("t8_wr0", b_wr, 16'hABCD, 8'h99);
    chk("t8_com", com, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
